// File: rtl/timer_cmp.sv
// Memory-mapped machine timer: prescaled 64-bit mtime, 64-bit mtimecmp and a level interrupt.
// A read of mtime_lo snapshots mtime_hi so that a lo-then-hi read sequence is tear-free.
module timer_cmp #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq,
  output logic        tick
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  localparam logic [1:0] REG_MTIME_LO = 2'd0;
  localparam logic [1:0] REG_MTIME_HI = 2'd1;
  localparam logic [1:0] REG_CMP_LO   = 2'd2;
  localparam logic [1:0] REG_CMP_HI   = 2'd3;

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [31:0]   snap_q, snap_d;
  logic [63:0]   cmp_q, cmp_d;
  logic [31:0]   dout_q, dout_d;
  logic          irq_q, irq_d;
  logic          tick_q, tick_d;

  logic       inc;
  logic       rd_en;
  logic       wr_en;
  logic [1:0] reg_sel;

  // Only addr[3:2] selects a register; the remaining bits are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  assign reg_sel = addr[3:2];
  assign rd_en   = sel & ~we;
  assign wr_en   = sel & we;
  assign inc     = (presc_q == PRESC_MAX);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    presc_d = inc ? '0 : presc_q + PW'(1);
    mtime_d = mtime_q + 64'(inc);
    tick_d  = inc;
    irq_d   = (mtime_q >= cmp_q);
    snap_d  = snap_q;
    cmp_d   = cmp_q;
    dout_d  = dout_q;

    // Reads use the pre-edge mtime, so a read on an increment edge sees the old value.
    if (rd_en) begin
      case (reg_sel)
        REG_MTIME_LO: begin
          dout_d = mtime_q[31:0];
          snap_d = mtime_q[63:32];
        end
        REG_MTIME_HI: dout_d = snap_q;
        REG_CMP_LO:   dout_d = cmp_q[31:0];
        REG_CMP_HI:   dout_d = cmp_q[63:32];
        default:      dout_d = dout_q;
      endcase
    end

    if (wr_en) begin
      case (reg_sel)
        REG_CMP_LO: cmp_d[31:0]  = din;
        REG_CMP_HI: cmp_d[63:32] = din;
        default:    cmp_d        = cmp_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      presc_q <= '0;
      mtime_q <= '0;
      snap_q  <= '0;
      cmp_q   <= '1;
      dout_q  <= '0;
      irq_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      snap_q  <= snap_d;
      cmp_q   <= cmp_d;
      dout_q  <= dout_d;
      irq_q   <= irq_d;
      tick_q  <= tick_d;
    end
  end

  assign dout = dout_q;
  assign irq  = irq_q;
  assign tick = tick_q;

endmodule
